// File: rtl/cpu_core_p.sv
// cpu_core_p: multi-cycle eight-register core with per-register flags,
// one shared memory port with a ready handshake, a halt state and a
// sticky illegal-opcode flag.
module cpu_core_p #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc
);

    localparam int unsigned NREG = 8;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_XOR  = 6'd5;
    localparam logic [5:0] OP_LDI  = 6'd6;
    localparam logic [5:0] OP_ST   = 6'd7;
    localparam logic [5:0] OP_LD   = 6'd8;
    localparam logic [5:0] OP_JMP  = 6'd9;
    localparam logic [5:0] OP_HALT = 6'd10;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];
    logic [NREG-1:0]     flags_q, flags_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                illegal_q, illegal_d;
    logic                halted_q, halted_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    // Instruction fields
    logic [5:0]          op;
    logic [2:0]          ra, rb, rd;
    logic                hl;
    logic [15:0]         imm;
    logic [DATA_W-1:0]   op_a, op_b, res;
    logic [DATA_W:0]     sum;
    logic [ADDR_W-1:0]   pc_inc, next_pc;
    logic                go_fetch;

    // Next-state, register-file and registered-output computation
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        regs_d      = regs_q;
        flags_d     = flags_q;
        pc_d        = pc_q;
        illegal_d   = illegal_q;
        halted_d    = halted_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        op       = ir_q[5:0];
        ra       = ir_q[8:6];
        rb       = ir_q[11:9];
        rd       = ir_q[14:12];
        hl       = ir_q[15];
        imm      = ir_q[31:16];
        op_a     = regs_q[ra];
        op_b     = regs_q[rb];
        sum      = {1'b0, op_a} + {1'b0, op_b};
        res      = '0;
        pc_inc   = pc_q + ADDR_W'(1);
        next_pc  = pc_inc;
        go_fetch = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d      = mem_rdata[31:0];
                    state_d   = S_EXEC;
                    mem_req_d = 1'b0;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_NOP: go_fetch = 1'b1;
                    OP_ADD: begin
                        regs_d[rd]  = sum[DATA_W-1:0];
                        flags_d[rd] = sum[DATA_W];
                        go_fetch    = 1'b1;
                    end
                    OP_SUB: begin
                        regs_d[rd]  = op_a - op_b;
                        flags_d[rd] = (op_a < op_b);
                        go_fetch    = 1'b1;
                    end
                    OP_AND, OP_OR, OP_XOR: begin
                        if (op == OP_AND)     res = op_a & op_b;
                        else if (op == OP_OR) res = op_a | op_b;
                        else                  res = op_a ^ op_b;
                        regs_d[rd]  = res;
                        flags_d[rd] = (res == '0);
                        go_fetch    = 1'b1;
                    end
                    OP_LDI: begin
                        regs_d[rd]  = hl ? DATA_W'({imm, op_b[15:0]}) : DATA_W'(imm);
                        flags_d[rd] = 1'b0;
                        go_fetch    = 1'b1;
                    end
                    OP_ST, OP_LD: begin
                        state_d    = S_MEM;
                        mem_req_d  = 1'b1;
                        mem_we_d   = (op == OP_ST);
                        mem_addr_d = op_a[ADDR_W-1:0];
                        if (op == OP_ST) mem_wdata_d = op_b;
                    end
                    OP_JMP: begin
                        if (hl || flags_q[rb]) next_pc = op_a[ADDR_W-1:0];
                        go_fetch = 1'b1;
                    end
                    OP_HALT: begin
                        state_d   = S_HALT;
                        halted_d  = 1'b1;
                        mem_req_d = 1'b0;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        go_fetch  = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op == OP_LD) begin
                        regs_d[rd]  = mem_rdata;
                        flags_d[rd] = (mem_rdata == '0);
                    end
                    go_fetch = 1'b1;
                end
            end
            S_HALT: begin
                mem_req_d = 1'b0;
                halted_d  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Common return to FETCH: request the next instruction immediately
        if (go_fetch) begin
            pc_d       = next_pc;
            state_d    = S_FETCH;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = next_pc;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            ir_q        <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            flags_q     <= '0;
            pc_q        <= RESET_PC;
            illegal_q   <= 1'b0;
            halted_q    <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= RESET_PC;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            regs_q      <= regs_d;
            flags_q     <= flags_d;
            pc_q        <= pc_d;
            illegal_q   <= illegal_d;
            halted_q    <= halted_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign pc        = pc_q;

endmodule
